clic_support_unit: RTL and testbench
====================================

// Module: clic_support_unit
// PURPOSE
//  Support datapath for the core-local interrupt controller (CLIC).
//  Bundles three CSR-mapped blocks and one buffer:
//   - a generic CSR register (interrupt threshold, `thresh`),
//   - a CSR-programmed periodic timer with a sticky interrupt flag,
//   - an EPC/priority LIFO stack used for interrupt nesting.
//  The controller above it drives push/pop, ext writes and timer clear.
// PARAMETERS
//  PrioWidth   3      width of thresh register and of its ext_data
//  StackDepth  8      number of stack entries
//  DataWidth   32     width of one stack entry
//  ThreshAddr  12'h347  CSR address of thresh
//  TimerAddr   12'h400  CSR address of timer config
//  IdxW        $clog2(StackDepth+1)  derived, not overridable
// PORTS
//  clk               in   1          clock
//  reset             in   1          async, active-high
//  csr_enable        in   1          CSR instruction valid this cycle
//  csr_addr          in   12         CSR address
//  csr_op            in   3          RISC-V funct3 (001 RW,010 RS,011 RC,101 RWI,110 RSI,111 RCI)
//  rs1_zimm          in   5          immediate for *I ops
//  rs1_data          in   32         rs1 value for register ops
//  thresh_ext_we     in   1          hardware write of thresh
//  thresh_ext_data   in   PrioWidth  hardware write value
//  timer_int_clear   in   1          clear sticky timer flag
//  push              in   1          push data_in
//  pop               in   1          pop top entry
//  data_in           in   DataWidth  stack write data
//  csr_out           out  32         CSR read data (pre-write value)
//  thresh            out  PrioWidth  current threshold
//  timer_int_set     out  1          sticky timer interrupt flag
//  stack_top         out  DataWidth  top-of-stack entry
//  stack_level       out  IdxW       number of valid entries
// BEHAVIOUR
//  Reset is asynchronous; all state clears to 0: thresh, timer cfg, counters, flag, stack, level.
//  CSR source operand:
//   src = rs1_data for op[2]=0; zero-extended rs1_zimm for op[2]=1.
//  CSR update on posedge clk when csr_enable && csr_addr==own address:
//   RW: reg=src; RS: reg|=src; RC: reg&=~src; result truncated to reg width.
//   Unknown op (000, 100): no write.
//  thresh: a CSR write and thresh_ext_we in the same cycle -> ext write wins.
//  csr_out is combinational:
//   - value before the write, zero-extended, when an owned address is presented;
//   - 0 for any other address, regardless of csr_enable.
//  Timer config (32 bit):
//   - [15:0] cmp; [31:28] ps; other bits read back 0.
//   - Tick every 2^ps clk cycles via prescaler counter.
//   - 16-bit count increments per tick.
//   - On the tick where count==cmp: count->0 and timer_int_set<=1 (sticky).
//   - cmp==0 disables the timer: count and prescaler held at 0.
//   - A write to the timer CSR resets count and prescaler to 0.
//  timer_int_clear:
//   - clears the flag next cycle;
//   - a set and a clear in the same cycle -> set wins.
//  Stack behaviour:
//   - push: mem[level]=data_in, level++.
//   - pop: level--.
//   - push&&pop together: replace top in place, level unchanged.
//   - Push when full is ignored; pop when empty is ignored.
//  stack_top = mem[level-1] combinationally; 0 when level==0.
//  All outputs are registered state except csr_out and stack_top; no extra latency.
// TESTING
//  1. RW thresh: csrrw 0x347, rs1=5 -> csr_out=0 that cycle; thresh=5 next cycle; reread csr_out=5.
//  2. RSI/RCI thresh: csrrsi zimm=2 on thresh=5 -> 7; then csrrci zimm=4 -> 3; same-cycle ext_we=1 with data 6 -> 6.
//  3. Timer: write 0x0000_0003 -> timer_int_set rises 4 cycles later, stays 1; clear -> 0; sets again 4 cycles on.
//  4. Prescale: write 0x1000_0002 (ps=1,cmp=2) -> flag after 6 cycles; cmp=0 -> flag never sets.
//  5. Stack: push A,B,C -> level=3, top=C; push&pop D -> level=3, top=D; pop x3 -> level=0; extra pop keeps level 0, top=0.
//  6. Overflow/reset: 9 pushes at depth 8 -> level=8, top=8th value; reset mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/clic_support_unit.sv
// rtl/clic_support_unit.sv - CLIC support datapath: threshold CSR, periodic timer, EPC/priority stack
module clic_support_unit #(
    parameter int          PrioWidth  = 3,
    parameter int          StackDepth = 8,
    parameter int          DataWidth  = 32,
    parameter logic [11:0] ThreshAddr = 12'h347,
    parameter logic [11:0] TimerAddr  = 12'h400,
    localparam int         IdxW       = $clog2(StackDepth + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_enable,
    input  logic [11:0]          csr_addr,
    input  logic [2:0]           csr_op,
    input  logic [4:0]           rs1_zimm,
    input  logic [31:0]          rs1_data,
    input  logic                 thresh_ext_we,
    input  logic [PrioWidth-1:0] thresh_ext_data,
    input  logic                 timer_int_clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] data_in,
    output logic [31:0]          csr_out,
    output logic [PrioWidth-1:0] thresh,
    output logic                 timer_int_set,
    output logic [DataWidth-1:0] stack_top,
    output logic [IdxW-1:0]      stack_level
);

    localparam int          AddrW      = (StackDepth > 1) ? $clog2(StackDepth) : 1;
    localparam logic [31:0] TimerMask  = 32'hF000_FFFF;
    localparam logic [IdxW-1:0] LevelFull = IdxW'(StackDepth);

    logic [PrioWidth-1:0] r_thresh;
    logic [31:0]          r_timer_cfg;
    logic [15:0]          r_timer_count;
    logic [15:0]          r_timer_presc;
    logic                 r_timer_flag;
    logic [DataWidth-1:0] r_mem [StackDepth];
    logic [IdxW-1:0]      r_level;

    logic [31:0]          w_src;
    logic [PrioWidth-1:0] w_src_prio;
    logic                 w_op_valid;
    logic                 w_thresh_hit;
    logic                 w_timer_wr;
    logic [PrioWidth-1:0] w_thresh_next;
    logic [31:0]          w_timer_new;
    logic [15:0]          w_timer_cmp;
    logic [15:0]          w_presc_max;
    logic                 w_tick;
    logic                 w_fire;
    logic [AddrW-1:0]     w_top_idx;
    logic [AddrW-1:0]     w_push_idx;
    logic                 w_do_replace;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Immediate forms (op[2]=1) take the zero-extended 5-bit zimm.
    assign w_src        = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;
    assign w_src_prio   = w_src[PrioWidth-1:0];
    assign w_op_valid   = (csr_op[1:0] != 2'b00);
    assign w_thresh_hit = csr_enable && (csr_addr == ThreshAddr) && w_op_valid;
    assign w_timer_wr   = csr_enable && (csr_addr == TimerAddr) && w_op_valid;

    always_comb begin
        w_thresh_next = r_thresh;
        if (thresh_ext_we) begin
            w_thresh_next = thresh_ext_data;
        end else if (w_thresh_hit) begin
            case (csr_op[1:0])
                2'b01:   w_thresh_next = w_src_prio;
                2'b10:   w_thresh_next = r_thresh | w_src_prio;
                2'b11:   w_thresh_next = r_thresh & ~w_src_prio;
                default: w_thresh_next = r_thresh;
            endcase
        end
    end

    always_comb begin
        case (csr_op[1:0])
            2'b01:   w_timer_new = w_src;
            2'b10:   w_timer_new = r_timer_cfg | w_src;
            2'b11:   w_timer_new = r_timer_cfg & ~w_src;
            default: w_timer_new = r_timer_cfg;
        endcase
    end

    always_comb begin
        csr_out = 32'd0;
        if (csr_addr == ThreshAddr) begin
            csr_out = {{(32-PrioWidth){1'b0}}, r_thresh};
        end else if (csr_addr == TimerAddr) begin
            csr_out = r_timer_cfg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thresh <= '0;
        end else begin
            r_thresh <= w_thresh_next;
        end
    end

    // Prescaler wraps at 2^ps-1; with ps=0 every cycle is a tick.
    assign w_timer_cmp = r_timer_cfg[15:0];
    assign w_presc_max = (16'd1 << r_timer_cfg[31:28]) - 16'd1;
    assign w_tick      = (w_timer_cmp != 16'd0) && (r_timer_presc == w_presc_max);
    assign w_fire      = !w_timer_wr && w_tick && (r_timer_count == w_timer_cmp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer_cfg   <= '0;
            r_timer_count <= '0;
            r_timer_presc <= '0;
            r_timer_flag  <= 1'b0;
        end else begin
            if (w_timer_wr) begin
                r_timer_cfg   <= w_timer_new & TimerMask;
                r_timer_count <= '0;
                r_timer_presc <= '0;
            end else if (w_timer_cmp == 16'd0) begin
                r_timer_count <= '0;
                r_timer_presc <= '0;
            end else if (w_tick) begin
                r_timer_presc <= '0;
                r_timer_count <= (r_timer_count == w_timer_cmp) ? 16'd0 : r_timer_count + 16'd1;
            end else begin
                r_timer_presc <= r_timer_presc + 16'd1;
            end

            if (w_fire) begin
                r_timer_flag <= 1'b1;
            end else if (timer_int_clear) begin
                r_timer_flag <= 1'b0;
            end
        end
    end

    // Simultaneous push/pop on an empty stack degenerates to a plain push.
    assign w_top_idx    = AddrW'(r_level - IdxW'(1));
    assign w_push_idx   = AddrW'(r_level);
    assign w_do_replace = push && pop && (r_level != '0);
    assign w_do_push    = push && !w_do_replace && (r_level != LevelFull);
    assign w_do_pop     = pop && !push && (r_level != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            for (int i = 0; i < StackDepth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_replace) begin
                r_mem[w_top_idx] <= data_in;
            end else if (w_do_push) begin
                r_mem[w_push_idx] <= data_in;
                r_level           <= r_level + IdxW'(1);
            end else if (w_do_pop) begin
                r_level <= r_level - IdxW'(1);
            end
        end
    end

    assign stack_top     = (r_level == '0) ? '0 : r_mem[w_top_idx];
    assign thresh        = r_thresh;
    assign timer_int_set = r_timer_flag;
    assign stack_level   = r_level;

endmodule

// File: tb/tb_clic_support_unit.sv
// tb/tb_clic_support_unit.sv - directed self-checking bench for clic_support_unit
module tb_clic_support_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data;
    logic        thresh_ext_we;
    logic [2:0]  thresh_ext_data;
    logic        timer_int_clear;
    logic        push;
    logic        pop;
    logic [31:0] data_in;
    logic [31:0] csr_out;
    logic [2:0]  thresh;
    logic        timer_int_set;
    logic [31:0] stack_top;
    logic [3:0]  stack_level;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] pre;

    clic_support_unit dut (
        .clk             (clk),
        .reset           (reset),
        .csr_enable      (csr_enable),
        .csr_addr        (csr_addr),
        .csr_op          (csr_op),
        .rs1_zimm        (rs1_zimm),
        .rs1_data        (rs1_data),
        .thresh_ext_we   (thresh_ext_we),
        .thresh_ext_data (thresh_ext_data),
        .timer_int_clear (timer_int_clear),
        .push            (push),
        .pop             (pop),
        .data_in         (data_in),
        .csr_out         (csr_out),
        .thresh          (thresh),
        .timer_int_set   (timer_int_set),
        .stack_top       (stack_top),
        .stack_level     (stack_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one CSR instruction; returns csr_out as seen before the write edge.
    task automatic csr(input logic [11:0] addr, input logic [2:0] op, input logic [4:0] zimm,
                       input logic [31:0] data, output logic [31:0] read_val);
        csr_enable = 1'b1;
        csr_addr   = addr;
        csr_op     = op;
        rs1_zimm   = zimm;
        rs1_data   = data;
        #1;
        read_val = csr_out;
        tick();
        csr_enable = 1'b0;
    endtask

    task automatic stack_op(input logic do_push, input logic do_pop, input logic [31:0] d);
        push    = do_push;
        pop     = do_pop;
        data_in = d;
        tick();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        csr_enable = 1'b0; csr_addr = 12'h0; csr_op = 3'b0; rs1_zimm = 5'd0; rs1_data = 32'd0;
        thresh_ext_we = 1'b0; thresh_ext_data = 3'd0; timer_int_clear = 1'b0;
        push = 1'b0; pop = 1'b0; data_in = 32'd0;
        repeat (2) tick();
        check("rst_thresh", 32'(thresh), 32'd0);
        check("rst_flag", 32'(timer_int_set), 32'd0);
        check("rst_level", 32'(stack_level), 32'd0);
        check("rst_top", stack_top, 32'd0);
        reset = 1'b0;
        tick();

        // thresh RW / RSI / RCI / ext priority
        csr(12'h347, 3'b001, 5'd0, 32'd5, pre);
        check("rw_pre", pre, 32'd0);
        check("rw_thresh", 32'(thresh), 32'd5);
        csr_addr = 12'h347; #1;
        check("rw_reread", csr_out, 32'd5);
        csr_addr = 12'h123; #1;
        check("other_addr", csr_out, 32'd0);
        csr(12'h347, 3'b110, 5'd2, 32'd0, pre);
        check("rsi_pre", pre, 32'd5);
        check("rsi_thresh", 32'(thresh), 32'd7);
        csr(12'h347, 3'b111, 5'd4, 32'd0, pre);
        check("rci_thresh", 32'(thresh), 32'd3);
        thresh_ext_we = 1'b1; thresh_ext_data = 3'd6;
        csr(12'h347, 3'b001, 5'd0, 32'd1, pre);
        thresh_ext_we = 1'b0;
        check("ext_wins", 32'(thresh), 32'd6);
        csr(12'h347, 3'b100, 5'd1, 32'd0, pre);
        check("unknown_op", 32'(thresh), 32'd6);
        csr(12'h347, 3'b011, 5'd0, 32'd2, pre);
        check("rc_thresh", 32'(thresh), 32'd4);
        csr(12'h346, 3'b001, 5'd0, 32'd1, pre);
        check("wrong_addr", 32'(thresh), 32'd4);

        // timer cmp=3, ps=0: sets on the 4th edge after the write
        csr(12'h400, 3'b001, 5'd0, 32'h0000_0003, pre);
        csr_addr = 12'h400; #1;
        check("tmr_readback", csr_out, 32'h0000_0003);
        repeat (3) tick();
        check("tmr_early", 32'(timer_int_set), 32'd0);
        tick();
        check("tmr_set", 32'(timer_int_set), 32'd1);
        tick();
        check("tmr_sticky", 32'(timer_int_set), 32'd1);
        timer_int_clear = 1'b1;
        tick();
        timer_int_clear = 1'b0;
        check("tmr_clear", 32'(timer_int_set), 32'd0);
        tick();
        check("tmr_gap", 32'(timer_int_set), 32'd0);
        tick();
        check("tmr_reset2", 32'(timer_int_set), 32'd1);
        timer_int_clear = 1'b1;
        tick();
        check("tmr_clr_hold", 32'(timer_int_set), 32'd0);
        repeat (3) tick();
        check("set_beats_clear", 32'(timer_int_set), 32'd1);

        // ps=1, cmp=2: six cycles; clear rides along with the write
        csr(12'h400, 3'b001, 5'd0, 32'h1000_0002, pre);
        timer_int_clear = 1'b0;
        check("ps_cleared", 32'(timer_int_set), 32'd0);
        repeat (5) tick();
        check("ps_early", 32'(timer_int_set), 32'd0);
        tick();
        check("ps_set", 32'(timer_int_set), 32'd1);
        csr(12'h400, 3'b001, 5'd0, 32'hFFFF_FFFF, pre);
        check("tmr_pre", pre, 32'h1000_0002);
        csr_addr = 12'h400; #1;
        check("tmr_mask", csr_out, 32'hF000_FFFF);
        timer_int_clear = 1'b1;
        csr(12'h400, 3'b001, 5'd0, 32'h0000_0000, pre);
        timer_int_clear = 1'b0;
        repeat (20) tick();
        check("cmp0_disabled", 32'(timer_int_set), 32'd0);

        // stack
        stack_op(1'b1, 1'b0, 32'hA);
        stack_op(1'b1, 1'b0, 32'hB);
        stack_op(1'b1, 1'b0, 32'hC);
        check("stk_lvl3", 32'(stack_level), 32'd3);
        check("stk_topC", stack_top, 32'hC);
        stack_op(1'b1, 1'b1, 32'hD);
        check("stk_repl_lvl", 32'(stack_level), 32'd3);
        check("stk_repl_top", stack_top, 32'hD);
        stack_op(1'b0, 1'b1, 32'h0);
        check("stk_pop_top", stack_top, 32'hB);
        stack_op(1'b0, 1'b1, 32'h0);
        stack_op(1'b0, 1'b1, 32'h0);
        check("stk_empty", 32'(stack_level), 32'd0);
        stack_op(1'b0, 1'b1, 32'h0);
        check("stk_underflow_lvl", 32'(stack_level), 32'd0);
        check("stk_underflow_top", stack_top, 32'd0);
        for (int i = 0; i < 9; i++) begin
            stack_op(1'b1, 1'b0, 32'd100 + 32'(i));
        end
        check("stk_full_lvl", 32'(stack_level), 32'd8);
        check("stk_full_top", stack_top, 32'd107);

        // asynchronous reset mid-cycle
        csr_addr = 12'h347;
        #2;
        reset = 1'b1;
        #1;
        check("arst_thresh", 32'(thresh), 32'd0);
        check("arst_csr_out", csr_out, 32'd0);
        check("arst_level", 32'(stack_level), 32'd0);
        check("arst_top", stack_top, 32'd0);
        check("arst_flag", 32'(timer_int_set), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
